// File: rtl/fadd_issue.sv
// fadd_issue: issue/retire pipeline around the combinational single-precision
// adder. Stage 1 registers the conditioned operands that feed the adder; the
// remaining STAGES-1 stages carry the captured sum and tag to writeback.
// Optional build macro: FADD_SPECIAL_EN (NaN/inf result substitution).
module fadd_issue #(
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_op,
   input  logic [31:0]                     in_a,
   input  logic [31:0]                     in_b,
   input  logic [TAG_W-1:0]                in_tag,
   output logic [31:0]                     add_x1,
   output logic [31:0]                     add_x2,
   input  logic [31:0]                     add_y,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [31:0]                     out_data,
   output logic [TAG_W-1:0]                out_tag,
   output logic [$clog2(STAGES+1)-1:0]     inflight
);
   localparam int CW = $clog2(STAGES+1);

   // vld/tag index 0 is the operand stage; res index 0 is the first result stage
   logic [STAGES-1:0]            vld_q, vld_d;
   logic [STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
   logic [STAGES-2:0][31:0]      res_q, res_d;
   logic [STAGES-1:0][31:0]      res_shift;
   logic [31:0]                  x1_q, x1_d, x2_q, x2_d;
   logic [31:0]                  b_flip;
   logic [31:0]                  cap;
   logic                         stall;

   // Denormal inputs are flushed to a zero of the same sign.
   function automatic logic [31:0] ftz(input logic [31:0] x);
      return (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
   endfunction

   assign b_flip    = {in_b[31] ^ in_op, in_b[30:0]};
   assign out_valid = vld_q[STAGES-1];
   assign out_data  = res_q[STAGES-2];
   assign out_tag   = tag_q[STAGES-1];
   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign add_x1    = x1_q;
   assign add_x2    = x2_q;
   assign inflight  = CW'($countones(vld_q));

`ifdef FADD_SPECIAL_EN
   logic nan_q, nan_d, inf_q, inf_d, inf_s_q, inf_s_d;
   logic a_nan, b_nan, a_inf, b_inf;

   // Special-case flags come from the raw operands (after the sub sign flip),
   // so a denormal flush can never mask them.
   always_comb begin
      a_nan   = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
      b_nan   = (b_flip[30:23] == 8'hFF) && (b_flip[22:0] != 23'd0);
      a_inf   = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
      b_inf   = (b_flip[30:23] == 8'hFF) && (b_flip[22:0] == 23'd0);
      nan_d   = a_nan | b_nan | (a_inf & b_inf & (in_a[31] ^ b_flip[31]));
      inf_d   = a_inf | b_inf;
      inf_s_d = a_inf ? in_a[31] : b_flip[31];
      if (stall) begin
         nan_d   = nan_q;
         inf_d   = inf_q;
         inf_s_d = inf_s_q;
      end
   end

   // Flag registers travel alongside the operand stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         nan_q   <= 1'b0;
         inf_q   <= 1'b0;
         inf_s_q <= 1'b0;
      end else begin
         nan_q   <= nan_d;
         inf_q   <= inf_d;
         inf_s_q <= inf_s_d;
      end
   end

   assign cap = nan_q ? 32'h7FC00000 : (inf_q ? {inf_s_q, 8'hFF, 23'd0} : add_y);
`else
   assign cap = add_y;
`endif

   assign res_shift = {res_q, cap};

   // Next state: hold everything on stall, otherwise shift one stage; flush
   // only kills valids (data left as don't-care).
   always_comb begin
      vld_d = vld_q;
      tag_d = tag_q;
      res_d = res_q;
      x1_d  = x1_q;
      x2_d  = x2_q;
      if (!stall) begin
         vld_d = {vld_q[STAGES-2:0], in_valid};
         tag_d = {tag_q[STAGES-2:0], in_tag};
         res_d = res_shift[STAGES-2:0];
         x1_d  = ftz(in_a);
         x2_d  = ftz(b_flip);
      end
      if (flush) vld_d = '0;
   end

   // Pipeline registers; reset takes priority over flush and handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         tag_q <= '0;
         res_q <= '0;
         x1_q  <= '0;
         x2_q  <= '0;
      end else begin
         vld_q <= vld_d;
         tag_q <= tag_d;
         res_q <= res_d;
         x1_q  <= x1_d;
         x2_q  <= x2_d;
      end
   end
endmodule

// File: tb/tb_fadd_issue.sv
// Bench for fadd_issue: directed cases plus randomized traffic scored against a
// queue model of accepted-but-undelivered operations.
module tb_fadd_issue;
   localparam int STAGES = 2;
   localparam int TAG_W  = 5;
   localparam int CW     = $clog2(STAGES+1);

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, in_op, out_valid, out_ready;
   logic [31:0]       in_a, in_b, add_x1, add_x2, add_y, out_data;
   logic [TAG_W-1:0]  in_tag, out_tag;
   logic [CW-1:0]     inflight;

   int checks = 0;
   int failures = 0;
   logic [31:0]      eq_d[$];
   logic [TAG_W-1:0] eq_t[$];

   always #5 clk = ~clk;

   fadd_issue #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .add_x1(add_x1), .add_x2(add_x2), .add_y(add_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .inflight(inflight));

   // single-precision <-> real through double bit patterns
   function automatic real sp2r(input logic [31:0] x);
      logic [63:0] bits;
      if (x[30:23] == 8'd0) bits = {x[31], 63'd0};
      else if (x[30:23] == 8'hFF) bits = {x[31], 11'h7FF, x[22:0], 29'd0};
      else bits = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
      return $bitstoreal(bits);
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] bits;
      int e;
      bits = $realtobits(r);
      if (bits[62:52] == 11'h7FF) return {bits[63], 8'hFF, bits[51:29]};
      e = int'(bits[62:52]) - 896;
      if (e >= 255) return {bits[63], 8'hFF, 23'd0};
      if (e <= 0) return {bits[63], 31'd0};
      return {bits[63], e[7:0], bits[51:29]};
   endfunction

   function automatic logic [31:0] fadd_m(input logic [31:0] x, input logic [31:0] y);
      return r2sp(sp2r(x) + sp2r(y));
   endfunction

   function automatic logic [31:0] ftz_m(input logic [31:0] x);
      return (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
   endfunction

`ifdef FADD_SPECIAL_EN
   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction
   function automatic logic is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
   endfunction
`endif

   // What writeback should see for one request.
   function automatic logic [31:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] bb;
      bb = {b[31] ^ op, b[30:0]};
`ifdef FADD_SPECIAL_EN
      if (is_nan(a) || is_nan(bb)) return 32'h7FC00000;
      if (is_inf(a) && is_inf(bb)) return (a[31] != bb[31]) ? 32'h7FC00000 : a;
      if (is_inf(a)) return a;
      if (is_inf(bb)) return bb;
`endif
      return fadd_m(ftz_m(a), ftz_m(bb));
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [7:0] e;
      case ($urandom_range(0, 7))
         0: e = 8'd0;
`ifdef FADD_SPECIAL_EN
         1: e = 8'hFF;
`endif
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {1'($urandom), e, 23'($urandom)};
   endfunction

   // stand-in for the combinational adder
   assign add_y = fadd_m(add_x1, add_x2);

   // scoreboard: one entry per accepted, not yet delivered operation
   always @(posedge clk) begin
      if (rst || flush) begin
         eq_d.delete();
         eq_t.delete();
      end else begin
         if (out_valid && out_ready && eq_d.size() > 0) begin
            void'(eq_d.pop_front());
            void'(eq_t.pop_front());
         end
         if (in_valid && in_ready) begin
            eq_d.push_back(model(in_op, in_a, in_b));
            eq_t.push_back(in_tag);
         end
      end
   end

   task automatic drive_rand(input logic v, input logic [TAG_W-1:0] t);
      in_valid = v;
      in_op    = 1'($urandom);
      in_a     = rnd_fp();
      in_b     = rnd_fp();
      in_tag   = t;
   endtask

   task automatic test_reset;
      rst = 1'b1; flush = 1'b1; drive_rand(1'b1, 5'd7); out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
      checks++; if (add_x1 !== 32'd0 || add_x2 !== 32'd0) begin failures++; $display("FAIL reset_operands got=%h/%h exp=0/0", add_x1, add_x2); end
      checks++; if (out_data !== 32'd0 || out_tag !== '0) begin failures++; $display("FAIL reset_out got=%h/%h exp=0/0", out_data, out_tag); end
      checks++; if (inflight !== '0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
   endtask

   task automatic test_operands;
      logic [31:0] ta[3], tb[3], tx1[3], tx2[3], ty[3];
      logic        top[3];
      ta = '{32'h3F800000, 32'h40400000, 32'h80000001};
      tb = '{32'h40000000, 32'h3F800000, 32'h3F800000};
      top = '{1'b0, 1'b1, 1'b0};
      tx1 = '{32'h3F800000, 32'h40400000, 32'h80000000};
      tx2 = '{32'h40000000, 32'hBF800000, 32'h3F800000};
      ty = '{32'h40400000, 32'h40000000, 32'h3F800000};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = top[k]; in_a = ta[k]; in_b = tb[k];
         in_tag = TAG_W'(k + 3); out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         checks++; if (add_x1 !== tx1[k] || add_x2 !== tx2[k]) begin failures++; $display("FAIL operands%0d got=%h/%h exp=%h/%h", k, add_x1, add_x2, tx1[k], tx2[k]); end
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL early_valid%0d got=%0h exp=0", k, out_valid); end
         @(negedge clk);
         #1;
         checks++; if (out_valid !== 1'b1 || out_data !== ty[k] || out_tag !== TAG_W'(k + 3))
            begin failures++; $display("FAIL result%0d got=%0h/%h/%0d exp=1/%h/%0d", k, out_valid, out_data, out_tag, ty[k], k + 3); end
         checks++; if (inflight !== CW'(1)) begin failures++; $display("FAIL result_inflight%0d got=%0d exp=1", k, inflight); end
      end
   endtask

   task automatic test_backpressure;
      int sent, rcv, hold;
      logic started;
      logic [31:0] hd;
      logic [TAG_W-1:0] ht;
      sent = 0; rcv = 0; hold = 0; started = 1'b0; hd = '0; ht = '0;
      for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
         @(negedge clk);
         if (out_valid && !started) begin started = 1'b1; hold = 3; hd = out_data; ht = out_tag; end
         out_ready = (hold == 0);
         drive_rand(sent < 4, TAG_W'(sent));
         #1;
         if (hold > 0) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0h exp=0", in_ready); end
            checks++; if (inflight !== CW'(2)) begin failures++; $display("FAIL bp_inflight got=%0d exp=2", inflight); end
            if (hold < 3) begin
               checks++; if (out_data !== hd || out_tag !== ht) begin failures++; $display("FAIL bp_hold got=%h/%0d exp=%h/%0d", out_data, out_tag, hd, ht); end
            end
            hold--;
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            checks++; if (out_tag !== TAG_W'(rcv)) begin failures++; $display("FAIL bp_order got=%0d exp=%0d", out_tag, rcv); end
            checks++; if (eq_d.size() == 0 || out_data !== eq_d[0]) begin failures++; $display("FAIL bp_data got=%h", out_data); end
            rcv++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (rcv != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", rcv); end
      checks++; if (out_valid !== 1'b0 || inflight !== '0) begin failures++; $display("FAIL bp_drain got=%0h/%0d exp=0/0", out_valid, inflight); end
   endtask

   task automatic fill2;
      out_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         drive_rand(1'b1, TAG_W'($urandom));
      end
      @(negedge clk);
   endtask

   task automatic test_flush_reset;
      fill2();
      flush = 1'b1; drive_rand(1'b1, 5'd9);
      #1;
      checks++; if (inflight !== CW'(2) || out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre got=%0d/%0h exp=2/1", inflight, out_valid); end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || inflight !== '0) begin failures++; $display("FAIL flush_post got=%0h/%0d exp=0/0", out_valid, inflight); end
      repeat (3) begin
         @(negedge clk);
         #1;
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost got=%0h exp=0", out_valid); end
      end
      fill2();
      rst = 1'b1; flush = 1'b1; drive_rand(1'b1, 5'd11);
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || inflight !== '0) begin failures++; $display("FAIL rstflush_valid got=%0h/%0d exp=0/0", out_valid, inflight); end
      checks++; if (add_x1 !== 32'd0 || add_x2 !== 32'd0 || out_data !== 32'd0 || out_tag !== '0)
         begin failures++; $display("FAIL rstflush_data got=%h/%h/%h/%0d exp=0", add_x1, add_x2, out_data, out_tag); end
   endtask

   task automatic test_special;
      logic [31:0] sa[4], sb[4];
      logic        sop[4];
`ifdef FADD_SPECIAL_EN
      logic [31:0] sy[4];
      sy = '{32'h7FC00000, 32'h7F800000, 32'h7FC00000, 32'h7F800000};
`else
      logic [31:0] ay;
`endif
      sa = '{32'h7F800000, 32'h7F800000, 32'h7FC00001, 32'h3F800000};
      sb = '{32'h7F800000, 32'h3F800000, 32'h40000000, 32'hFF800000};
      sop = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = sop[k]; in_a = sa[k]; in_b = sb[k];
         in_tag = TAG_W'(20 + k); out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         #1;
`ifndef FADD_SPECIAL_EN
         ay = add_y;
`endif
         @(negedge clk);
         #1;
`ifdef FADD_SPECIAL_EN
         checks++; if (out_valid !== 1'b1 || out_data !== sy[k]) begin failures++; $display("FAIL special%0d got=%0h/%h exp=1/%h", k, out_valid, out_data, sy[k]); end
`else
         checks++; if (out_valid !== 1'b1 || out_data !== ay) begin failures++; $display("FAIL passthru%0d got=%0h/%h exp=1/%h", k, out_valid, out_data, ay); end
`endif
      end
   endtask

   task automatic test_random;
      logic pstall;
      logic [31:0] pd;
      logic [TAG_W-1:0] pt;
      pstall = 1'b0; pd = '0; pt = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         flush = ($urandom_range(0, 39) == 0);
         drive_rand(1'($urandom), TAG_W'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         checks++; if (in_ready !== !(out_valid && !out_ready)) begin failures++; $display("FAIL rnd_ready got=%0h ov=%0h or=%0h", in_ready, out_valid, out_ready); end
         checks++; if (int'(inflight) != eq_d.size()) begin failures++; $display("FAIL rnd_inflight got=%0d exp=%0d", inflight, eq_d.size()); end
         if (pstall) begin
            checks++; if (out_valid !== 1'b1 || out_data !== pd || out_tag !== pt) begin failures++; $display("FAIL rnd_hold got=%h/%0d exp=%h/%0d", out_data, out_tag, pd, pt); end
         end
         if (out_valid) begin
            checks++; if (eq_d.size() == 0 || out_data !== eq_d[0] || out_tag !== eq_t[0]) begin failures++; $display("FAIL rnd_result got=%h/%0d", out_data, out_tag); end
         end
         pstall = out_valid && !out_ready && !flush;
         pd = out_data; pt = out_tag;
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (STAGES + 2) @(negedge clk);
      #1;
      checks++; if (eq_d.size() != 0 || inflight !== '0) begin failures++; $display("FAIL rnd_drain got=%0d/%0d exp=0/0", eq_d.size(), inflight); end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 1'b0;
      in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
      test_reset();
      test_operands();
      test_backpressure();
      test_flush_reset();
      test_special();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fadd_issue.md
Name: fadd_issue

Overview:
Pipelined issue/retire stage wrapped around the team's combinational single-precision adder (fadd).
- Upstream side: accepts add/sub requests from the FPU dispatch with a valid/ready handshake.
- Operand conditioning: flips the subtrahend's sign and flushes denormals, then drives the adder from a registered operand stage.
- Downstream side: captures the adder result into a fixed-depth result pipeline with tags and backpressure.
- Sits between FPU dispatch and FPU writeback arbitration.

Parameters:
STAGES, 2, total latency in cycles from accept edge to out_valid (minimum 2: one operand stage plus STAGES-1 result stages).
TAG_W, 5, width of the destination-register tag carried alongside each operation.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all in-flight operations
in_valid  input  1  request present
in_ready  output  1  stage can accept this cycle
in_op  input  1  0 = a+b, 1 = a-b
in_a  input  32  IEEE-754 single operand a
in_b  input  32  IEEE-754 single operand b
in_tag  input  TAG_W  destination tag
add_x1  output  32  operand 1 to adder (registered)
add_x2  output  32  operand 2 to adder (registered)
add_y  input  32  adder result (combinational from add_x1/add_x2)
out_valid  output  1  result present
out_ready  input  1  writeback accepts result
out_data  output  32  result
out_tag  output  TAG_W  tag of result
inflight  output  $clog2(STAGES+1)  number of valid stages

Behaviour:
- Reset (rst high at edge): all stage valids 0, add_x1 = add_x2 = 0, out_data = 0, out_tag = 0, inflight = 0. Reset wins over flush and over any handshake in the same cycle.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall. It is combinational from out_valid/out_ready and does not depend on in_valid.
  - While stall is high, every stage register holds.
- Advance (~stall):
  - Each stage shifts by one; stage 1 loads the new request.
  - Stage 1 valid = in_valid.
  - The last result stage drives out_valid/out_data/out_tag.
  - Bubbles propagate as valid = 0.
- Operand conditioning at stage-1 load:
  - b' = in_b with bit 31 XORed with in_op.
  - Any operand with exponent 0 is replaced by signed zero (sign kept, exp and mantissa zeroed).
  - add_x1 = conditioned a, add_x2 = conditioned b'.
- Result capture: when stage 1 advances into stage 2, stage 2 data = add_y (or the special result when the optional feature is enabled) and stage 2 tag = stage-1 tag.
- Latency: a request accepted at edge t with no stalls has out_valid high after edge t+STAGES-1. Back-to-back accepts give one result per cycle.
- flush (not rst):
  - All valids clear at the edge, including the request accepted that same cycle.
  - Data registers are don't-care.
  - out_valid is low the next cycle.
- inflight = count of valid stages, updated each edge; range 0..STAGES.
- Holding rule: out_data and out_tag must not change while out_valid & ~out_ready.

Optional Feature:
FADD_SPECIAL_EN. When defined, stage 1 also registers special-case flags from the unconditioned operands, and the result stage substitutes for add_y:
- either operand NaN -> 0x7FC00000
- +inf + -inf (after sub sign flip) -> 0x7FC00000
- one operand inf -> that inf with its sign (after flip)

When not defined, add_y is passed through unmodified for all inputs and no extra flag registers exist.

Test Plan:
- Add, STAGES=2: in_a=0x3F800000, in_b=0x40000000, in_op=0, tag=3, accept at edge 0 -> add_x1=0x3F800000 and add_x2=0x40000000 after edge 0; out_valid=1, out_data=0x40400000, out_tag=3 after edge 1.
- Subtract: a=0x40400000, b=0x3F800000, op=1 -> add_x2=0xBF800000; out_data=0x40000000.
- Denormal flush: a=0x80000001, b=0x3F800000, op=0 -> add_x1=0x80000000; out_data=0x3F800000.
- Backpressure: stream 4 requests with tags 0..3, hold out_ready=0 from the first out_valid for 3 cycles -> in_ready=0 during the hold; out_data and out_tag stable; inflight=2; all 4 results delivered in order after release, none lost or duplicated.
- Flush and reset:
  - Flush with 2 in flight while in_valid=1 -> out_valid=0 the next cycle, inflight=0, no result for any of the 3 operations.
  - Asserting rst in the same cycle as flush gives the reset values.
- Special values, macro defined:
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000.
  - 0x7F800000 + 0x3F800000 -> 0x7F800000.
  - 0x7FC00001 + any -> 0x7FC00000.
  - Macro undefined: bench checks out_data equals add_y as sampled.
